// File: rtl/mac_wb_arbiter_if.sv
// Write-back bus between the MAC array and the arbiter, plus the DA PRAM write port it drives.
interface mac_wb_arbiter_if #(
  parameter int MAC_N     = 4,
  parameter int D_LEN     = 16,
  parameter int DA_AWIDTH = 8,
  parameter int OFS_WIDTH = 2,
  parameter int CELL_N    = 4
);
  logic [MAC_N-1:0]           wb_req;
  logic [MAC_N*D_LEN-1:0]     wb_data;
  logic [MAC_N*DA_AWIDTH-1:0] wb_base;
  logic [MAC_N*OFS_WIDTH-1:0] wb_ofs;
  logic [MAC_N-1:0]           wb_ack;
  logic [DA_AWIDTH-1:0]       da_addr;
  logic [D_LEN-1:0]           da_din;
  logic [CELL_N-1:0]          da_wen;
  logic                       busy;
  logic [2:0]                 grant_id;
  logic                       ofs_err;

  modport master (
    output wb_req, wb_data, wb_base, wb_ofs,
    input  wb_ack, da_addr, da_din, da_wen, busy, grant_id, ofs_err
  );

  modport slave (
    input  wb_req, wb_data, wb_base, wb_ofs,
    output wb_ack, da_addr, da_din, da_wen, busy, grant_id, ofs_err
  );
endinterface

// File: rtl/mac_wb_arbiter.sv
// Round-robin arbiter serialising MAC write-back posts onto the single DA PRAM write port.
// Optional `MAC_WB_PRIO0_EN: MAC 0 gets fixed top priority, MACs 1..MAC_N-1 rotate among themselves.
module mac_wb_arbiter #(
  parameter int MAC_N     = 4,
  parameter int D_LEN     = 16,
  parameter int DA_AWIDTH = 8,
  parameter int OFS_WIDTH = 2,
  parameter int CELL_N    = 4,
  parameter int WR_SETTLE = 2
) (
  input logic             clk,
  input logic             rst_n,
  mac_wb_arbiter_if.slave bus
);
  localparam int CW = (WR_SETTLE > 1) ? $clog2(WR_SETTLE) : 1;

`ifdef MAC_WB_PRIO0_EN
  localparam logic [2:0] RR_INIT = 3'd1;
`else
  localparam logic [2:0] RR_INIT = 3'd0;
`endif

  typedef enum logic [2:0] {IDLE, GRANT, SETTLE, WRITE, ACK} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [OFS_WIDTH-1:0] ofs_q;
  logic [2:0]           rr;
  logic [2:0]           rr_next;
  logic                 found;
  logic [2:0]           pick;

  // Winner search: first pending request at or above rr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = 3'd0;
    idx   = 0;
`ifdef MAC_WB_PRIO0_EN
    if (bus.wb_req[0]) begin
      found = 1'b1;
    end
    for (int k = 0; k < MAC_N - 1; k++) begin
      idx = 1 + ((int'(rr) - 1 + k) % (MAC_N - 1));
      if (!found && bus.wb_req[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
`else
    for (int k = 0; k < MAC_N; k++) begin
      idx = (int'(rr) + k) % MAC_N;
      if (!found && bus.wb_req[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
`endif
  end

  // Pointer moves past the MAC just served; with fixed MAC 0 priority it never lands on 0.
  always_comb begin
`ifdef MAC_WB_PRIO0_EN
    if (bus.grant_id == 3'd0) begin
      rr_next = rr;
    end else if (int'(bus.grant_id) == MAC_N - 1) begin
      rr_next = 3'd1;
    end else begin
      rr_next = bus.grant_id + 3'd1;
    end
`else
    if (int'(bus.grant_id) == MAC_N - 1) begin
      rr_next = 3'd0;
    end else begin
      rr_next = bus.grant_id + 3'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ofs_q        <= '0;
      rr           <= RR_INIT;
      bus.wb_ack   <= '0;
      bus.da_addr  <= '0;
      bus.da_din   <= '0;
      bus.da_wen   <= '0;
      bus.busy     <= 1'b0;
      bus.grant_id <= 3'd0;
      bus.ofs_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state        <= GRANT;
            bus.busy     <= 1'b1;
            bus.grant_id <= pick;
            bus.da_addr  <= bus.wb_base[int'(pick)*DA_AWIDTH +: DA_AWIDTH];
            bus.da_din   <= bus.wb_data[int'(pick)*D_LEN +: D_LEN];
            ofs_q        <= bus.wb_ofs[int'(pick)*OFS_WIDTH +: OFS_WIDTH];
          end
        end
        GRANT: begin
          state <= SETTLE;
          cnt   <= '0;
        end
        SETTLE: begin
          if (cnt == CW'(WR_SETTLE - 1)) begin
            state <= WRITE;
            // An out-of-range offset suppresses the write but the post is still acknowledged.
            if (int'(ofs_q) < CELL_N) begin
              bus.da_wen <= CELL_N'(1) << ofs_q;
            end else begin
              bus.ofs_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          state      <= ACK;
          bus.da_wen <= '0;
          bus.wb_ack <= MAC_N'(1) << bus.grant_id;
        end
        ACK: begin
          state      <= IDLE;
          bus.wb_ack <= '0;
          bus.busy   <= 1'b0;
          rr         <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_wb_arbiter.sv
// Scoreboard bench for mac_wb_arbiter: directed posts push expected acks, a monitor pops and checks them.
module tb_mac_wb_arbiter;
  localparam int MAC_N     = 4;
  localparam int D_LEN     = 16;
  localparam int DA_AWIDTH = 8;
  localparam int OFS_WIDTH = 2;
  localparam int CELL_N    = 3;
  localparam int WR_SETTLE = 2;

  typedef struct {
    int          id;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [2:0]  wen;
    logic        err;
    int          gap;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;
  int   reload [MAC_N];
  exp_t sb [$];

  exp_t       e;
  logic       busy_d       = 1'b0;
  logic       ack_d        = 1'b0;
  logic [2:0] wen_d        = 3'd0;
  int         grant_cyc    = 0;
  int         last_ack_cyc = 0;

  mac_wb_arbiter_if #(.MAC_N(MAC_N), .D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH),
                      .OFS_WIDTH(OFS_WIDTH), .CELL_N(CELL_N)) bus ();

  mac_wb_arbiter #(.MAC_N(MAC_N), .D_LEN(D_LEN), .DA_AWIDTH(DA_AWIDTH), .OFS_WIDTH(OFS_WIDTH),
                   .CELL_N(CELL_N), .WR_SETTLE(WR_SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int id, input logic [7:0] addr, input logic [15:0] data,
                         input logic [2:0] wen, input logic err, input int gap);
    exp_t x;
    x.id = id; x.addr = addr; x.data = data; x.wen = wen; x.err = err; x.gap = gap;
    sb.push_back(x);
  endtask

  task automatic setPayload(input int i, input logic [7:0] base, input logic [1:0] ofs,
                            input logic [15:0] data);
    bus.wb_base[i*DA_AWIDTH +: DA_AWIDTH] = base;
    bus.wb_ofs[i*OFS_WIDTH +: OFS_WIDTH]  = ofs;
    bus.wb_data[i*D_LEN +: D_LEN]         = data;
  endtask

  // Raise requests, then act as the requesters: drop (or re-post) on ack, optionally tamper mid-write.
  task automatic applyStimulus(input logic [MAC_N-1:0] mask, input int n_acks, input int tamper);
    int got = 0;
    bit done = 1'b0;
    bus.wb_req = bus.wb_req | mask;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (tamper > 0 && k == tamper) begin
        for (int i = 0; i < MAC_N; i++) begin
          if (mask[i]) begin
            setPayload(i, 8'hff, 2'd0, 16'hdead);
            bus.wb_req[i] = 1'b0;
          end
        end
      end
      for (int i = 0; i < MAC_N; i++) begin
        if (bus.wb_ack[i]) begin
          got++;
          if (reload[i] > 0) begin
            reload[i]--;
            bus.wb_data[i*D_LEN +: D_LEN] = bus.wb_data[i*D_LEN +: D_LEN] + 16'd1;
          end else begin
            bus.wb_req[i] = 1'b0;
          end
        end
      end
      if (got >= n_acks) done = 1'b1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ack_timeout: got %0d acks, expected %0d", got, n_acks);
    end
  endtask

  // Monitor: checks grant payload, write-enable latency, and each ack against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_d = 1'b0;
      ack_d  = 1'b0;
      wen_d  = 3'd0;
    end else begin
      if (bus.busy && !busy_d) begin
        grant_cyc = cycle;
        if (sb.size() > 0) begin
          checkOutput("grant_id", 32'(bus.grant_id), 32'(sb[0].id));
          checkOutput("grant_addr", 32'(bus.da_addr), 32'(sb[0].addr));
          checkOutput("grant_din", 32'(bus.da_din), 32'(sb[0].data));
        end
      end
      if (bus.da_wen != 3'd0) checkOutput("wen_latency", 32'(cycle - grant_cyc), 32'd3);
      if (ack_d) begin
        checkOutput("ack_single_cycle", 32'(bus.wb_ack), 32'd0);
      end else if (bus.wb_ack != '0) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_ack: got 0x%0h, expected none", bus.wb_ack);
        end else begin
          e = sb.pop_front();
          checkOutput("ack_onehot", 32'(bus.wb_ack), 32'(1) << e.id);
          checkOutput("ack_wen", 32'(wen_d), 32'(e.wen));
          checkOutput("ack_addr", 32'(bus.da_addr), 32'(e.addr));
          checkOutput("ack_din", 32'(bus.da_din), 32'(e.data));
          checkOutput("ack_ofs_err", 32'(bus.ofs_err), 32'(e.err));
          checkOutput("ack_latency", 32'(cycle - grant_cyc), 32'd4);
          if (e.gap > 0) checkOutput("ack_gap", 32'(cycle - last_ack_cyc), 32'(e.gap));
        end
        last_ack_cyc = cycle;
      end
      busy_d = bus.busy;
      ack_d  = (bus.wb_ack != '0);
      wen_d  = bus.da_wen;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.wb_req  = '0;
    bus.wb_data = '0;
    bus.wb_base = '0;
    bus.wb_ofs  = '0;
    for (int i = 0; i < MAC_N; i++) reload[i] = 0;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_da_addr", 32'(bus.da_addr), 32'd0);
    checkOutput("rst_da_din", 32'(bus.da_din), 32'd0);
    checkOutput("rst_da_wen", 32'(bus.da_wen), 32'd0);
    checkOutput("rst_wb_ack", 32'(bus.wb_ack), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("rst_ofs_err", 32'(bus.ofs_err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    // Single write from MAC 2 (rr 0 -> 3)
    setPayload(2, 8'h15, 2'd1, 16'h1234);
    pushExp(2, 8'h15, 16'h1234, 3'b010, 1'b0, 0);
    applyStimulus(4'b0100, 1, 0);

    // Wrap: MAC 3 alone (rr -> 0), then MAC 0 and 3 together -> 0 first
    setPayload(3, 8'h33, 2'd0, 16'h3333);
    pushExp(3, 8'h33, 16'h3333, 3'b001, 1'b0, 0);
    applyStimulus(4'b1000, 1, 0);
    setPayload(0, 8'h20, 2'd2, 16'ha0a0);
    setPayload(3, 8'h34, 2'd1, 16'h3434);
    pushExp(0, 8'h20, 16'ha0a0, 3'b100, 1'b0, 0);
    pushExp(3, 8'h34, 16'h3434, 3'b010, 1'b0, 6);
    applyStimulus(4'b1001, 2, 0);

    // Contention: all four at once from rr 0 -> 0,1,2,3 six cycles apart
    for (int i = 0; i < MAC_N; i++) setPayload(i, 8'(8'h50 + i), 2'(i % 3), 16'(16'h1000 * (i + 1) + i));
    pushExp(0, 8'h50, 16'h1000, 3'b001, 1'b0, 0);
    pushExp(1, 8'h51, 16'h2001, 3'b010, 1'b0, 6);
    pushExp(2, 8'h52, 16'h3002, 3'b100, 1'b0, 6);
    pushExp(3, 8'h53, 16'h4003, 3'b001, 1'b0, 6);
    applyStimulus(4'b1111, 4, 0);

    // Payload latched at grant; request dropped mid-write still completes (rr -> 2)
    setPayload(1, 8'h40, 2'd2, 16'hbeef);
    pushExp(1, 8'h40, 16'hbeef, 3'b100, 1'b0, 0);
    applyStimulus(4'b0010, 1, 1);

    // Single requester back-to-back (rr -> 3)
    setPayload(2, 8'h66, 2'd0, 16'h0100);
    reload[2] = 1;
    pushExp(2, 8'h66, 16'h0100, 3'b001, 1'b0, 0);
    pushExp(2, 8'h66, 16'h0101, 3'b001, 1'b0, 6);
    applyStimulus(4'b0100, 2, 0);

    // Bad offset, then a good write with ofs_err still sticky (rr -> 2 -> 3)
    setPayload(1, 8'h77, 2'd3, 16'h7777);
    pushExp(1, 8'h77, 16'h7777, 3'b000, 1'b1, 0);
    applyStimulus(4'b0010, 1, 0);
    setPayload(2, 8'h88, 2'd1, 16'h8888);
    pushExp(2, 8'h88, 16'h8888, 3'b010, 1'b1, 0);
    applyStimulus(4'b0100, 1, 0);

    // Reset during SETTLE aborts the write
    setPayload(2, 8'h99, 2'd0, 16'h9999);
    bus.wb_req[2] = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("pre_abort_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_da_addr", 32'(bus.da_addr), 32'd0);
    checkOutput("abort_da_din", 32'(bus.da_din), 32'd0);
    checkOutput("abort_grant_id", 32'(bus.grant_id), 32'd0);
    checkOutput("abort_ofs_err", 32'(bus.ofs_err), 32'd0);
    checkOutput("abort_wb_ack", 32'(bus.wb_ack), 32'd0);
    repeat (2) @(negedge clk);

    // After release rr is 0 again, so MAC 2 beats MAC 3
    setPayload(3, 8'haa, 2'd2, 16'haaaa);
    pushExp(2, 8'h99, 16'h9999, 3'b001, 1'b0, 0);
    pushExp(3, 8'haa, 16'haaaa, 3'b100, 1'b0, 6);
    rst_n = 1'b1;
    applyStimulus(4'b1100, 2, 0);

    repeat (8) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    checkOutput("final_busy", 32'(bus.busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
